// File: rtl/mult_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_sched_pkg
// Description : Shared Q1.15 audio constants and saturation helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_sched_pkg;

    localparam int c_q15_bits = 16;
    localparam int c_q15_frac = 15;

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam logic [c_q15_bits-1:0] c_q15_max = c_q15_bits'(sat_max(c_q15_bits));
    localparam logic [c_q15_bits-1:0] c_q15_min = c_q15_bits'(sat_min(c_q15_bits));

endpackage
`default_nettype wire

// File: rtl/mult_sched_core.sv
`default_nettype none
// ============================================================================
// Module      : mult_sched_core
// Description : Two-stage signed fractional multiply with saturation and tag.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sched_core
    import mult_sched_pkg::*;
#(
    parameter int BITSIZE = c_q15_bits,
    parameter int TAG_W   = 2
) (
    input  logic               clk,
    input  logic               i_resetn,
    input  logic               i_valid,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic [BITSIZE-1:0] i_a,
    input  logic [BITSIZE-1:0] i_b,
    output logic               o_valid,
    output logic [TAG_W-1:0]   o_tag,
    output logic [BITSIZE-1:0] o_result,
    output logic               o_busy
);

    localparam logic [BITSIZE-1:0] c_max = BITSIZE'(sat_max(BITSIZE));

    logic                 r_v1;
    logic                 r_v2;
    logic [TAG_W-1:0]     r_tag1;
    logic [TAG_W-1:0]     r_tag2;
    logic [BITSIZE-1:0]   r_a;
    logic [BITSIZE-1:0]   r_b;
    logic [BITSIZE-1:0]   r_result;

    logic [2*BITSIZE-1:0] w_a_ext;
    logic [2*BITSIZE-1:0] w_b_ext;
    logic [2*BITSIZE-1:0] w_prod;
    logic [BITSIZE-1:0]   w_sat;
    logic                 w_unused_lsbs;

    assign w_a_ext = {{BITSIZE{r_a[BITSIZE-1]}}, r_a};
    assign w_b_ext = {{BITSIZE{r_b[BITSIZE-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Only -1.0 * -1.0 yields a positive product whose top two bits read 01.
    always_comb begin
        w_sat = w_prod[2*BITSIZE-2 -: BITSIZE];
        if (!w_prod[2*BITSIZE-1] && w_prod[2*BITSIZE-2]) begin
            w_sat = c_max;
        end
    end

    assign w_unused_lsbs = ^w_prod[BITSIZE-2:0];

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_tag1   <= '0;
            r_tag2   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            if (i_valid) begin
                r_a    <= i_a;
                r_b    <= i_b;
                r_tag1 <= i_tag;
            end
            if (r_v1) begin
                r_result <= w_sat;
                r_tag2   <= r_tag1;
            end
        end
    end

    assign o_valid  = r_v2;
    assign o_tag    = r_tag2;
    assign o_result = r_result;
    assign o_busy   = r_v1 | r_v2;

endmodule
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : mult_sched
// Description : Shares one pipelined Q1.15 multiplier among NREQ requesters.
//               MULT_SCHED_ROUND_ROBIN_EN selects round-robin arbitration,
//               otherwise fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int BITSIZE = c_q15_bits,
    parameter int NREQ    = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BITSIZE-1:0] op_a,
    input  logic [NREQ*BITSIZE-1:0] op_b,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic [BITSIZE-1:0]      result,
    output logic                    busy
);

    localparam int c_tag_w = tag_width(NREQ);

    logic               r_run;
    logic               w_grant_valid;
    logic [c_tag_w-1:0] w_grant_idx;
    logic               w_issue;
    logic               w_core_valid;
    logic [c_tag_w-1:0] w_core_tag;
    logic [BITSIZE-1:0] w_a_arr [NREQ];
    logic [BITSIZE-1:0] w_b_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign w_a_arr[gi] = op_a[gi*BITSIZE +: BITSIZE];
        assign w_b_arr[gi] = op_b[gi*BITSIZE +: BITSIZE];
    end

    // Holds off grants until the first clock edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

`ifdef MULT_SCHED_ROUND_ROBIN_EN
    logic [c_tag_w-1:0] r_ptr;

    // Descending scan: the candidate closest after r_ptr is assigned last.
    always_comb begin
        int idx;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (req[idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = c_tag_w'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_grant_idx == c_tag_w'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = c_tag_w'(i);
            end
        end
    end
`endif

    assign w_issue = w_grant_valid & r_run;

    always_comb begin
        ack = '0;
        if (w_issue) begin
            ack[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        done = '0;
        if (w_core_valid) begin
            done[w_core_tag] = 1'b1;
        end
    end

    mult_sched_core #(
        .BITSIZE (BITSIZE),
        .TAG_W   (c_tag_w)
    ) u_core (
        .clk      (clk),
        .i_resetn (resetn),
        .i_valid  (w_issue),
        .i_tag    (w_grant_idx),
        .i_a      (w_a_arr[w_grant_idx]),
        .i_b      (w_b_arr[w_grant_idx]),
        .o_valid  (w_core_valid),
        .o_tag    (w_core_tag),
        .o_result (result),
        .o_busy   (busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_sched
// Description : Directed self-checking bench for mult_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sched;

    logic        clk;
    logic        resetn;
    logic [3:0]  req;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [15:0] result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    mult_sched #(
        .BITSIZE (16),
        .NREQ    (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .op_a   (op_a),
        .op_b   (op_b),
        .ack    (ack),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        op_a[i*16 +: 16] = a;
        op_b[i*16 +: 16] = b;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_edge();
        resetn = 1'b0;
        drive_edge();
        resetn = 1'b1;
        drive_edge();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [3:0]  exp_ack;
        logic [3:0]  exp_done;
        logic [15:0] exp_res;

        resetn = 1'b0;
        req    = 4'b0100;
        op_a   = '0;
        op_b   = '0;
        set_op(2, 16'h4000, 16'h4000);

        // Reset state with a request already pending.
        repeat (3) @(posedge clk);
        sample();
        check("rst_ack", ack, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_result", result, 16'h0000);
        check("rst_busy", busy, 1'b0);
        resetn = 1'b1;
        #1;
        check("no_grant_before_edge", ack, 4'b0000);

        // Single request: 0.5 * 0.5 = 0.25
        drive_edge();
        sample();
        check("single_ack", ack, 4'b0100);
        check("single_busy_T", busy, 1'b0);
        drive_edge();
        req = 4'b0000;
        sample();
        check("single_ack_T1", ack, 4'b0000);
        check("single_done_T1", done, 4'b0000);
        check("single_busy_T1", busy, 1'b1);
        drive_edge();
        sample();
        check("single_done_T2", done, 4'b0100);
        check("single_result", result, 16'h2000);
        drive_edge();
        sample();
        check("single_done_T3", done, 4'b0000);
        check("single_result_hold", result, 16'h2000);
        check("single_busy_T3", busy, 1'b0);

        // Saturation and the most negative non-overflowing product.
        drive_edge();
        set_op(0, 16'h8000, 16'h8000);
        req = 4'b0001;
        sample();
        check("sat_ack0", ack, 4'b0001);
        drive_edge();
        set_op(0, 16'h8000, 16'h7FFF);
        sample();
        check("sat_ack1", ack, 4'b0001);
        drive_edge();
        req = 4'b0000;
        sample();
        check("sat_done0", done, 4'b0001);
        check("sat_result_max", result, 16'h7FFF);
        drive_edge();
        sample();
        check("sat_done1", done, 4'b0001);
        check("sat_result_neg", result, 16'h8001);
        drive_edge();
        sample();
        check("sat_idle_done", done, 4'b0000);
        check("sat_idle_busy", busy, 1'b0);

        // Early release: operands change after grant, captured ones are used.
        drive_edge();
        set_op(1, 16'h2000, 16'hC000);
        req = 4'b0010;
        sample();
        check("rel_ack", ack, 4'b0010);
        drive_edge();
        req = 4'b0000;
        set_op(1, 16'h7FFF, 16'h7FFF);
        sample();
        check("rel_ack_T1", ack, 4'b0000);
        check("rel_done_T1", done, 4'b0000);
        drive_edge();
        sample();
        check("rel_done_T2", done, 4'b0010);
        check("rel_result", result, 16'hF000);

`ifdef MULT_SCHED_ROUND_ROBIN_EN
        // Round robin with all requesters held: results are (i+1)*0x0800.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_op(i, 16'h4000, 16'((i + 1) << 12));
        end
        for (int k = 0; k < 8; k++) begin
            drive_edge();
            req = (k < 5) ? 4'hF : 4'h0;
            sample();
            exp_ack  = (k < 5) ? 4'(1 << (k % 4)) : 4'h0;
            exp_done = (k >= 2 && k < 7) ? 4'(1 << ((k - 2) % 4)) : 4'h0;
            check($sformatf("rr_ack_%0d", k), ack, exp_ack);
            check($sformatf("rr_done_%0d", k), done, exp_done);
            check($sformatf("rr_busy_%0d", k), busy, (k >= 1 && k <= 6) ? 1'b1 : 1'b0);
            if (k >= 2 && k < 7) begin
                exp_res = 16'((((k - 2) % 4) + 1) * 16'h0800);
                check($sformatf("rr_result_%0d", k), result, exp_res);
            end
        end
`else
        // Fixed priority: requester 1 starves requester 3 while held.
        set_op(1, 16'h4000, 16'h2000);
        set_op(3, 16'hFFFF, 16'h0001);
        for (int k = 0; k < 10; k++) begin
            drive_edge();
            req = (k < 6) ? 4'b1010 : ((k == 6) ? 4'b1000 : 4'b0000);
            sample();
            exp_ack  = (k < 6) ? 4'b0010 : ((k == 6) ? 4'b1000 : 4'b0000);
            exp_done = (k >= 2 && k <= 7) ? 4'b0010 : ((k == 8) ? 4'b1000 : 4'b0000);
            check($sformatf("fp_ack_%0d", k), ack, exp_ack);
            check($sformatf("fp_done_%0d", k), done, exp_done);
            check($sformatf("fp_busy_%0d", k), busy, (k >= 1 && k <= 8) ? 1'b1 : 1'b0);
            if (k >= 2 && k <= 7) begin
                check($sformatf("fp_result_%0d", k), result, 16'h1000);
            end
            if (k == 8) begin
                check("fp_result_trunc", result, 16'hFFFF);
            end
        end
`endif

        // Reset asserted while an operation is in flight.
        do_reset();
        drive_edge();
        set_op(0, 16'h4000, 16'h4000);
        req = 4'b0001;
        sample();
        check("mid_ack", ack, 4'b0001);
        drive_edge();
        req = 4'b0000;
        sample();
        check("mid_busy_before", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("mid_busy_rst", busy, 1'b0);
        check("mid_done_rst", done, 4'b0000);
        check("mid_result_rst", result, 16'h0000);
        drive_edge();
        resetn = 1'b1;
        sample();
        check("mid_done_T2", done, 4'b0000);
        drive_edge();
        sample();
        check("mid_done_T3", done, 4'b0000);
        check("mid_busy_T3", busy, 1'b0);
        check("mid_result_T3", result, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter BITSIZE, default 16, sample width of every operand and result.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters sharing the multiplier.
REQ-003 SHALL have port clk, input, 1, the single clock (system clock domain).
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, NREQ, request bit per requester.
REQ-006 SHALL have port op_a, input, NREQ*BITSIZE, signed Q1.15 operand A per requester; requester i uses slice i.
REQ-007 SHALL have port op_b, input, NREQ*BITSIZE, signed Q1.15 operand B per requester; same slicing.
REQ-008 SHALL have port ack, output, NREQ, one-hot grant pulse.
REQ-009 SHALL have port done, output, NREQ, one-hot result-valid pulse.
REQ-010 SHALL have port result, output, BITSIZE, shared signed Q1.15 product bus.
REQ-011 SHALL have port busy, output, 1, high while any pipeline stage holds a valid operation.

Function
REQ-012 SHALL grant at most one requester per cycle, only among those with req high.
REQ-013 SHALL raise ack[i] for exactly the grant cycle and capture op_a/op_b slice i on that clk edge.
REQ-014 SHALL raise done[i] and present the product on result exactly 2 cycles after ack[i] (stage 1: operand register, stage 2: product register).
REQ-015 SHALL accept a new grant every cycle (fully pipelined, no bubbles while requests pend).
REQ-016 SHALL carry the requester index with each operation so done always matches the granted index.
REQ-017 SHALL compute result = (a*b) >>> (BITSIZE-1) on the full 2*BITSIZE signed product, truncating toward minus infinity.
REQ-018 SHALL saturate the single overflow case (-1.0 * -1.0) to the maximum positive value (0x7FFF at BITSIZE=16).
REQ-019 SHALL treat req held high after ack as a new request, eligible from the next cycle.
REQ-020 SHALL ignore req deassertion after ack; the captured operation still completes.
REQ-021 SHALL hold result at its last value when no done bit is high.
REQ-022 SHALL hold busy high from the cycle after any ack until the cycle after the last done.

Reset
REQ-023 SHALL, on resetn low, immediately clear ack, done, result, busy, all pipeline valid bits and tags, and set the arbitration pointer to 0.
REQ-024 SHALL discard operations in flight when reset is asserted mid-operation; no done is produced for them.
REQ-025 SHALL issue the first grant no earlier than the first clk edge after resetn deasserts.

Configuration
REQ-026 SHALL, when MULT_SCHED_ROUND_ROBIN_EN is defined, use round-robin: search starts at the index after the last grant and wraps from NREQ-1 to 0.
REQ-027 SHALL, when MULT_SCHED_ROUND_ROBIN_EN is undefined, use fixed priority: the lowest index wins, and the pointer logic is absent.

Structure
REQ-028 SHALL take Q1.15 width constants and the saturation max/min values from the shared audio package used by the other DSP blocks.
REQ-029 SHALL place the 2-stage signed multiply-and-saturate datapath in sub-module mult_sched_core; arbitration and tag logic stay in mult_sched.

Verification
REQ-030 SHALL check a single request: req[2]=1, a=0x4000, b=0x4000 -> ack[2] in cycle T, done[2] at T+2, result=0x2000.
REQ-031 SHALL check saturation: a=0x8000, b=0x8000 -> result=0x7FFF; a=0x8000, b=0x7FFF -> result=0x8001.
REQ-032 SHALL check round-robin (macro defined), all four req held high -> acks 0,1,2,3,0 on consecutive cycles, dones in the same order 2 cycles later, busy continuously high.
REQ-033 SHALL check fixed priority (macro undefined), req=4'b1010 held -> ack[1] every cycle, requester 3 is never granted.
REQ-034 SHALL check reset mid-operation: resetn pulsed low 1 cycle after ack[0] -> no done[0], result=0, busy=0.
REQ-035 SHALL check early release: req[1] dropped the cycle after ack[1] -> done[1] still at T+2 with the product of the captured operands.
